serial_addsub: RTL

- Bit-serial WIDTH-bit adder/subtractor controller, one operand bit per clock, LSB first.
- Sequences operands through a single one-bit add/sub cell and holds the carry/borrow between bits.
- Assembles the result word and reports the final carry/borrow.
- Sits between the operand-issuing control logic and any downstream consumer of the result; trades latency for a one-cell datapath.

---
 rtl/serial_addsub_pkg.sv | 19 +
 rtl/serial_bit_cell.sv | 24 ++
 rtl/serial_addsub.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state
// encoding and the add/subtract mode constants.
package serial_addsub_pkg;

    // State codes kept as plain constants so older code can still compare against them.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage : serial_addsub_pkg

// File: rtl/serial_bit_cell.sv
// One-bit add/subtract cell. In subtract mode cin/cout carry the borrow,
// so the chain computes A - B with an initial borrow of zero.
module serial_bit_cell
    import serial_addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    // Sum bit is the same for add and subtract; only the carry/borrow rule differs.
    always_comb begin
        s = a ^ b ^ cin;
        if (mode == MODE_SUB) begin
            cout = (~a & b) | (~a & cin) | (b & cin);
        end else begin
            cout = (a & b) | (a & cin) | (b & cin);
        end
    end

endmodule : serial_bit_cell

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor controller. Operands are latched
// on an accepted start and fed LSB first through a single serial_bit_cell;
// the result word is assembled by shifting sums in at the MSB.
// Optional feature macro: SERIAL_ADDSUB_OVF_EN enables the signed overflow
// flag; without it the ovf port is tied low.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_reg;
    state_e           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             mode_reg;
    logic             carry_reg;
    logic             cell_s;
    logic             cell_cout;
    logic             last_bit;

    assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

    serial_bit_cell u_cell (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .mode (mode_reg),
        .s    (cell_s),
        .cout (cell_cout)
    );

    // Next-state logic: start is only looked at in IDLE, DONE lasts one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, operand shifters, bit counter, carry and result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            cnt_reg    <= '0;
            mode_reg   <= MODE_ADD;
            carry_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        mode_reg   <= mode;
                        result_reg <= '0;
                        cnt_reg    <= '0;
                        carry_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    a_reg      <= a_reg >> 1;
                    b_reg      <= b_reg >> 1;
                    result_reg <= {cell_s, result_reg[WIDTH-1:1]};
                    carry_reg  <= cell_cout;
                    // Counter parks on the last bit index rather than wrapping.
                    if (!last_bit) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic ovf_reg;

    // Capture operand sign bits at accept and judge overflow on the final bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (state_reg == IDLE && start) begin
            a_msb_reg <= a[WIDTH-1];
            b_msb_reg <= b[WIDTH-1];
            ovf_reg   <= 1'b0;
        end else if (last_bit) begin
            if (mode_reg == MODE_SUB) begin
                ovf_reg <= (a_msb_reg != b_msb_reg) && (cell_s != a_msb_reg);
            end else begin
                ovf_reg <= (a_msb_reg == b_msb_reg) && (cell_s != a_msb_reg);
            end
        end
    end

    assign ovf = ovf_reg;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;
    assign carry  = carry_reg;

endmodule : serial_addsub
